// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: FSM state, default widths per MIPS stage register, control field layout.
// No logic; latency and backpressure belong to the modules that import it.
// Field offsets let a consumer unpack the CTRL_W-bit control bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    localparam int CTRL_W_DEFAULT = 11;

    localparam int DATA_W_IF_ID  = 64;   // instr, pc+4
    localparam int DATA_W_ID_EX  = 143;  // rs/rt values, imm, pc+4, rs/rt/rd
    localparam int DATA_W_EX_MEM = 69;   // alu result, rt value, rd
    localparam int DATA_W_MEM_WB = 69;   // mem data, alu result, rd

    localparam int CTRL_ALU_FUNC_LSB = 0;
    localparam int CTRL_ALU_FUNC_W   = 5;
    localparam int CTRL_ALU_SRC      = 5;
    localparam int CTRL_REG_WRITE    = 6;
    localparam int CTRL_REG_DST      = 7;
    localparam int CTRL_MEM_READ     = 8;
    localparam int CTRL_MEM_WRITE    = 9;
    localparam int CTRL_MEM_TO_REG   = 10;

    typedef struct packed {
        logic                       mem_to_reg;
        logic                       mem_write;
        logic                       mem_read;
        logic                       reg_dst;
        logic                       reg_write;
        logic                       alu_src;
        logic [CTRL_ALU_FUNC_W-1:0] alu_func;
    } ctrl_t;

    function automatic ctrl_t unpack_ctrl(input logic [CTRL_W_DEFAULT-1:0] v);
        ctrl_t c;
        c.mem_to_reg = v[CTRL_MEM_TO_REG];
        c.mem_write  = v[CTRL_MEM_WRITE];
        c.mem_read   = v[CTRL_MEM_READ];
        c.reg_dst    = v[CTRL_REG_DST];
        c.reg_write  = v[CTRL_REG_WRITE];
        c.alu_src    = v[CTRL_ALU_SRC];
        c.alu_func   = v[CTRL_ALU_FUNC_LSB +: CTRL_ALU_FUNC_W];
        return c;
    endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One valid-tagged control+data register with load and clear; clear zeroes valid and control.
// Latency: 1 cycle from load to output.
// Backpressure: none; the owner decides when to load or clear (clear wins).
module pipe_stage_entry #(
    parameter int CTRL_W = pipe_pkg::CTRL_W_DEFAULT,
    parameter int DATA_W = pipe_pkg::DATA_W_ID_EX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              vld,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            ctrl <= '0;
            data <= '0;
        end else if (clr) begin
            vld  <= 1'b0;
            ctrl <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            ctrl <= ld_ctrl;
            data <= ld_data;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready, optional 2-entry skid, flush and stall.
// Latency: 1 cycle, 1 transfer/cycle with out_ready high. Optional counters: PIPE_STAGE_BUF_STATS_EN.
// Backpressure: SKID=1 registered in_ready (low only when both entries full); SKID=0 combinational.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int DATA_W = DATA_W_ID_EX,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_BUF_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
`endif
    output logic [DATA_W-1:0] out_data
);

    logic              in_xfer;
    logic              out_xfer;
    logic              main_vld;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_vld & out_ready;
    assign out_valid = main_vld;
    // Bubbles must never present a register write or memory access downstream.
    assign out_ctrl  = main_vld ? main_ctrl : '0;
    assign out_data  = main_data;

    generate
        if (SKID) begin : g_skid
            stage_state_t      state;
            logic              full;
            logic              main_load, main_clr, skid_load, skid_clr;
            logic              skid_vld;
            logic [CTRL_W-1:0] skid_ctrl, main_src_ctrl;
            logic [DATA_W-1:0] skid_data, main_src_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state <= EMPTY;
                    full  <= 1'b0;
                end else if (flush) begin
                    state <= EMPTY;
                    full  <= 1'b0;
                end else begin
                    case (state)
                        EMPTY: if (in_xfer) state <= ONE;
                        ONE: begin
                            if (in_xfer && !out_xfer) begin
                                state <= TWO;
                                full  <= 1'b1;
                            end else if (!in_xfer && out_xfer) begin
                                state <= EMPTY;
                            end
                        end
                        TWO: begin
                            if (out_xfer) begin
                                state <= ONE;
                                full  <= 1'b0;
                            end
                        end
                        default: begin
                            state <= EMPTY;
                            full  <= 1'b0;
                        end
                    endcase
                end
            end

            assign in_ready = !full & !rst;

            always_comb begin
                main_clr  = flush | (out_xfer & !in_xfer & (state != TWO));
                main_load = (in_xfer & ((state == EMPTY) | ((state == ONE) & out_xfer)))
                          | ((state == TWO) & out_xfer);
                skid_load = in_xfer & (state == ONE) & !out_xfer;
                skid_clr  = flush | ((state == TWO) & out_xfer);
            end

            // When the skid holds an entry it is older than anything on the input.
            assign main_src_ctrl = skid_vld ? skid_ctrl : in_ctrl;
            assign main_src_data = skid_vld ? skid_data : in_data;

            pipe_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
                .clk(clk), .rst(rst), .clr(main_clr), .load(main_load),
                .ld_ctrl(main_src_ctrl), .ld_data(main_src_data),
                .vld(main_vld), .ctrl(main_ctrl), .data(main_data)
            );

            pipe_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk(clk), .rst(rst), .clr(skid_clr), .load(skid_load),
                .ld_ctrl(in_ctrl), .ld_data(in_data),
                .vld(skid_vld), .ctrl(skid_ctrl), .data(skid_data)
            );
        end else begin : g_single
            logic main_clr;

            assign in_ready = !rst & (!main_vld | out_ready);
            assign main_clr = flush | (out_xfer & !in_xfer);

            pipe_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
                .clk(clk), .rst(rst), .clr(main_clr), .load(in_xfer),
                .ld_ctrl(in_ctrl), .ld_data(in_data),
                .vld(main_vld), .ctrl(main_ctrl), .data(main_data)
            );
        end
    endgenerate

`ifdef PIPE_STAGE_BUF_STATS_EN
    logic kill;
    // in_ready low with a valid main entry means the skid is occupied too (SKID=1 only).
    assign kill = in_xfer | (main_vld & (!out_ready | !in_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_vld && !out_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && kill && bubble_cnt != 32'hFFFF_FFFF)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios plus random traffic on a SKID=1 and a SKID=0 instance,
// checked against a queue model of an ordered buffer with capacity 2 or 1.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int CW = CTRL_W_DEFAULT;
    localparam int DW = DATA_W_ID_EX;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;

    logic          flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [CW-1:0] in_ctrl0, out_ctrl0;
    logic [DW-1:0] in_data0, out_data0;

`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [31:0] stall_cnt, bubble_cnt, stall_cnt0, bubble_cnt0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ent_t q1[$];
    ent_t q0[$];

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
`ifdef PIPE_STAGE_BUF_STATS_EN
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
        .out_data(out_data)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0),
`ifdef PIPE_STAGE_BUF_STATS_EN
        .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0),
`endif
        .out_data(out_data0)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        flush = 0; in_valid = 0; out_ready = 0; in_ctrl = '0; in_data = '0;
        flush0 = 0; in_valid0 = 0; out_ready0 = 0; in_ctrl0 = '0; in_data0 = '0;
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_ctrl !== '0) begin n_bad++; $display("FAIL rst_out_ctrl got=%h exp=0", out_ctrl); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (in_ready0 !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready0 got=%b exp=0", in_ready0); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (in_ready0 !== 1'b1) begin n_bad++; $display("FAIL rel_in_ready0 got=%b exp=1", in_ready0); end
    endtask

    task automatic test_pass();
        logic [CW-1:0] c[4];
        logic [DW-1:0] d[4];
        c[0] = 11'h5A3;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) c[k] = CW'($urandom_range(1, 2047));
            d[k] = rand_data();
        end
        @(negedge clk);
        out_ready = 1; in_valid = 1; in_ctrl = c[0]; in_data = d[0];
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pass_valid k=%0d got=%b exp=1", k, out_valid); end
            n_cmp++; if (out_ctrl !== c[k-1]) begin n_bad++; $display("FAIL pass_ctrl k=%0d got=%h exp=%h", k, out_ctrl, c[k-1]); end
            n_cmp++; if (out_data !== d[k-1]) begin n_bad++; $display("FAIL pass_data k=%0d got=%h exp=%h", k, out_data, d[k-1]); end
            if (k < 4) begin in_ctrl = c[k]; in_data = d[k]; end
            else in_valid = 0;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pass_drain got=%b exp=0", out_valid); end
        n_cmp++; if (out_ctrl !== '0) begin n_bad++; $display("FAIL pass_bubble_ctrl got=%h exp=0", out_ctrl); end
    endtask

    task automatic test_stall();
        logic [CW-1:0] ca, cb;
        logic [DW-1:0] da, db;
        ca = 11'h123; cb = 11'h456; da = rand_data(); db = rand_data();
        @(negedge clk);
        in_valid = 1; in_ctrl = ca; in_data = da; out_ready = 0;
        @(negedge clk);
        n_cmp++; if (out_ctrl !== ca) begin n_bad++; $display("FAIL stall_a_ctrl got=%h exp=%h", out_ctrl, ca); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_one_rdy got=%b exp=1", in_ready); end
        in_ctrl = cb; in_data = db;
        @(negedge clk);
        in_valid = 0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_two_rdy got=%b exp=0", in_ready); end
        n_cmp++; if (out_ctrl !== ca) begin n_bad++; $display("FAIL stall_hold_ctrl got=%h exp=%h", out_ctrl, ca); end
        @(negedge clk);
        n_cmp++; if (out_data !== da) begin n_bad++; $display("FAIL stall_hold_data got=%h exp=%h", out_data, da); end
        n_cmp++; if (out_ctrl !== ca) begin n_bad++; $display("FAIL stall_hold_ctrl2 got=%h exp=%h", out_ctrl, ca); end
        out_ready = 1;
        @(negedge clk);
        n_cmp++; if (out_ctrl !== cb) begin n_bad++; $display("FAIL stall_b_ctrl got=%h exp=%h", out_ctrl, cb); end
        n_cmp++; if (out_data !== db) begin n_bad++; $display("FAIL stall_b_data got=%h exp=%h", out_data, db); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_rdy_back got=%b exp=1", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush_two();
        @(negedge clk);
        in_valid = 1; in_ctrl = 11'h0A1; in_data = rand_data(); out_ready = 0;
        @(negedge clk);
        in_ctrl = 11'h0B2; in_data = rand_data();
        @(negedge clk);
        flush = 1; in_ctrl = 11'h0C3; in_data = rand_data();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_ctrl !== '0) begin n_bad++; $display("FAIL flush_ctrl got=%h exp=0", out_ctrl); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_rdy got=%b exp=1", in_ready); end
        flush = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_c got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1; in_ctrl = 11'h3FF; in_data = rand_data(); out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre_valid got=%b exp=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_ctrl !== '0) begin n_bad++; $display("FAIL arst_ctrl got=%h exp=0", out_ctrl); end
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_empty got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_rdy got=%b exp=1", in_ready); end
    endtask

    task automatic test_skid0();
        logic [DW-1:0] dx, dy;
        dx = rand_data(); dy = rand_data();
        @(negedge clk);
        in_valid0 = 1; in_ctrl0 = 11'h111; in_data0 = dx; out_ready0 = 0;
        @(negedge clk);
        #1;
        n_cmp++; if (out_data0 !== dx) begin n_bad++; $display("FAIL s0_x_data got=%h exp=%h", out_data0, dx); end
        n_cmp++; if (in_ready0 !== 1'b0) begin n_bad++; $display("FAIL s0_stall_rdy got=%b exp=0", in_ready0); end
        in_ctrl0 = 11'h222; in_data0 = dy; out_ready0 = 1;
        #1;
        n_cmp++; if (in_ready0 !== 1'b1) begin n_bad++; $display("FAIL s0_comb_rdy got=%b exp=1", in_ready0); end
        @(negedge clk);
        n_cmp++; if (out_ctrl0 !== 11'h222) begin n_bad++; $display("FAIL s0_y_ctrl got=%h exp=222", out_ctrl0); end
        n_cmp++; if (out_data0 !== dy) begin n_bad++; $display("FAIL s0_y_data got=%h exp=%h", out_data0, dy); end
        in_valid0 = 0;
        @(negedge clk);
        n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL s0_drain got=%b exp=0", out_valid0); end
    endtask

`ifdef PIPE_STAGE_BUF_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        #1 rst = 0;
        @(negedge clk);
        in_valid = 1; in_ctrl = 11'h0AA; in_data = rand_data();
        @(negedge clk);
        in_valid = 0;
        repeat (4) @(negedge clk);
        flush = 1; in_valid = 1; out_ready = 1; in_ctrl = 11'h0BB;
        @(negedge clk);
        flush = 1; in_valid = 0;
        n_cmp++; if (stall_cnt !== 32'd4) begin n_bad++; $display("FAIL stats_stall got=%0d exp=4", stall_cnt); end
        n_cmp++; if (bubble_cnt !== 32'd1) begin n_bad++; $display("FAIL stats_bubble got=%0d exp=1", bubble_cnt); end
        @(negedge clk);
        flush = 0;
        n_cmp++; if (bubble_cnt !== 32'd1) begin n_bad++; $display("FAIL stats_empty_flush got=%0d exp=1", bubble_cnt); end
    endtask
`endif

    task automatic test_random();
        bit ix1, ox1, ix0, ox0, v1, v0, r1, r0;
        @(negedge clk);
        rst = 1;
        flush = 0; in_valid = 0; out_ready = 0; flush0 = 0; in_valid0 = 0; out_ready0 = 0;
        #1 rst = 0;
        q1.delete(); q0.delete();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            v1 = q1.size() > 0;
            v0 = q0.size() > 0;
            n_cmp++; if (out_valid !== v1) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, v1); end
            n_cmp++; if (out_valid0 !== v0) begin n_bad++; $display("FAIL rnd_valid0 cyc=%0d got=%b exp=%b", i, out_valid0, v0); end
            if (v1) begin
                n_cmp++; if ({out_ctrl, out_data} !== q1[0]) begin n_bad++; $display("FAIL rnd_out cyc=%0d got=%h exp=%h", i, {out_ctrl, out_data}, q1[0]); end
            end else begin
                n_cmp++; if (out_ctrl !== '0) begin n_bad++; $display("FAIL rnd_bubble cyc=%0d got=%h exp=0", i, out_ctrl); end
            end
            if (v0) begin
                n_cmp++; if ({out_ctrl0, out_data0} !== q0[0]) begin n_bad++; $display("FAIL rnd_out0 cyc=%0d got=%h exp=%h", i, {out_ctrl0, out_data0}, q0[0]); end
            end else begin
                n_cmp++; if (out_ctrl0 !== '0) begin n_bad++; $display("FAIL rnd_bubble0 cyc=%0d got=%h exp=0", i, out_ctrl0); end
            end
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 15) == 0;
            in_ctrl   = CW'($urandom_range(0, 2047));
            in_data   = rand_data();
            in_valid0  = $urandom_range(0, 3) != 0;
            out_ready0 = $urandom_range(0, 2) != 0;
            flush0     = $urandom_range(0, 15) == 0;
            in_ctrl0   = CW'($urandom_range(0, 2047));
            in_data0   = rand_data();
            #1;
            r1 = q1.size() < 2;
            r0 = (q0.size() == 0) || out_ready0;
            n_cmp++; if (in_ready !== r1) begin n_bad++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", i, in_ready, r1); end
            n_cmp++; if (in_ready0 !== r0) begin n_bad++; $display("FAIL rnd_rdy0 cyc=%0d got=%b exp=%b", i, in_ready0, r0); end
            ix1 = in_valid & r1;   ox1 = v1 & out_ready;
            ix0 = in_valid0 & r0;  ox0 = v0 & out_ready0;
            @(posedge clk);
            if (flush) q1.delete();
            else begin
                if (ox1) void'(q1.pop_front());
                if (ix1) q1.push_back({in_ctrl, in_data});
            end
            if (flush0) q0.delete();
            else begin
                if (ox0) void'(q0.pop_front());
                if (ix0) q0.push_back({in_ctrl0, in_data0});
            end
        end
        @(negedge clk);
        flush = 0; in_valid = 0; flush0 = 0; in_valid0 = 0;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_stall();
        test_flush_two();
        test_async_reset();
        test_skid0();
`ifdef PIPE_STAGE_BUF_STATS_EN
        test_stats();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised successor to the fixed-field ID/EX-style stage register. It is a generic pipeline stage that carries a control bundle and a data bundle between two pipeline stages, using a valid/ready handshake, a 2-entry skid buffer, synchronous flush (bubble insertion) and stall. One instance replaces each hand-written IF/ID, ID/EX, EX/MEM and MEM/WB register in the MIPS pipeline.

Parameters:
CTRL_W, 11, width of control bundle (ALU function, ALU source, register write, register destination, memory read/write, mem-to-reg)
DATA_W, 143, width of data bundle (operands, immediate, PC+4, rs/rt/rd)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous; kill all held entries and the current input
in_valid  input  1  upstream stage has a valid instruction
in_ready  output  1  stage can accept this cycle
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  stage holds a valid instruction
out_ready  input  1  downstream accepts (0 = stall)
out_ctrl  output  CTRL_W  control to the next stage; forced to 0 when out_valid=0
out_data  output  DATA_W  data to the next stage; don't-care when out_valid=0

Behaviour:
- Transfer in: in_valid & in_ready at posedge. Transfer out: out_valid & out_ready at posedge.
- Reset (async, immediate): state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, in_ready=0 while rst is high and 1 on the first cycle after release; the skid entry is cleared.
- SKID=1 FSM states: EMPTY, ONE (main entry valid), TWO (main and skid valid).
  - EMPTY: on in xfer -> ONE, main<=in.
  - ONE: in xfer with no out xfer -> TWO, skid<=in. In xfer with out xfer -> ONE, main<=in. Out xfer only -> EMPTY.
  - TWO: on out xfer -> ONE, main<=skid. No input is accepted in TWO.
  - in_ready is registered and equals 1 exactly when the next state is not TWO.
- SKID=0: a single entry. in_ready = !out_valid | out_ready (combinational). Latency is 1 cycle and there is no skid state.
- Latency: an input accepted at edge N appears on out_* after edge N, with 1-cycle latency. Throughput is 1 per cycle when out_ready is held at 1.
- Order is strictly FIFO. Data is never duplicated or dropped, except by flush.
- Stall: when out_ready=0, out_* stay held bit-exact across cycles.
- Flush at an edge:
  - next state=EMPTY and out_valid=0; the main and skid control fields are zeroed.
  - A concurrent in xfer is discarded. A concurrent out xfer still counts as consumed downstream.
  - Flush has priority over every other event. in_ready is 1 the next cycle.
- Reset mid-operation: all entries are lost immediately and there is no partial transfer.
- out_ctrl is gated with the valid bit, so a bubble always presents all-zero control (no register write, no memory access).
- The stage performs no arithmetic. Widths pass through unchanged.

Optional Feature:
Macro PIPE_STAGE_BUF_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0], both reset to 0 by rst.
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments on each flush that kills at least one valid entry or input.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: no counter ports and no counter logic. Handshake behaviour is identical in both builds.

Decomposition:
- Shared package pipe_pkg:
  - state typedef {EMPTY, ONE, TWO};
  - CTRL_W default constant;
  - per-stage DATA_W constants (IF_ID, ID_EX, EX_MEM, MEM_WB);
  - control field offsets for unpacking at the consumer.
- Sub-module pipe_stage_entry: one valid-tagged CTRL_W+DATA_W register with load and clear. It is instantiated twice (main, skid) when SKID=1 and once when SKID=0.

Test Plan:
1. Reset release, then in_valid=1, in_ctrl=11'h5A3, in_data=A, out_ready=1 -> edge+1: out_valid=1, out_ctrl=11'h5A3, out_data=A. With a new input every cycle, throughput is 1 per cycle.
2. Stall with SKID=1: send A then B, out_ready=0 for 3 cycles. -> After A: state ONE, in_ready=1. After B: state TWO, in_ready=0. out shows A, held stable. Release out_ready -> A, then B, in order; in_ready returns to 1 after the A out xfer.
3. Flush in state TWO with a concurrent in_valid carrying C -> next cycle out_valid=0, out_ctrl=0, in_ready=1. C never appears on the output.
4. Async reset asserted mid-cycle while holding A -> out_valid and out_ctrl go to 0 before the next edge. After release the stage is empty.
5. SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 -> pass-through with 1-cycle latency and no loss.
6. STATS_EN build: 4 stall cycles, then 1 flush of a valid entry -> stall_cnt=4, bubble_cnt=1. A flush of an empty stage with in_valid=0 leaves bubble_cnt=1.
